// File: rtl/lza_pkg.sv
// rtl/lza_pkg.sv - shared helpers for the pipelined leading-zero anticipator
// Count-width sizing and the MSB-first priority index used by every group encoder.
package lza_pkg;

  function automatic int lza_cw(input int w);
    return $clog2(w + 1);
  endfunction

  // Number of zeros above the highest set bit among the low n bits of v (0 when none set).
  function automatic int lead_idx(input logic [63:0] v, input int n);
    int r;
    r = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < n && v[i]) r = n - 1 - i;
    end
    return r;
  endfunction

endpackage

// File: rtl/lza_group_enc.sv
// rtl/lza_group_enc.sv - N-bit MSB-first priority encoder returning {any, local index}
// Used per GROUP-bit slice of the indicator and again across the group "any" bits.
module lza_group_enc
  import lza_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  bits,
  output logic          any,
  output logic [IW-1:0] idx
);

  always_comb begin
    any = |bits;
    idx = IW'(lead_idx(64'(bits), N));
  end

endmodule

// File: rtl/lza_pipe.sv
// rtl/lza_pipe.sv - pipelined leading-zero anticipator with valid/ready handshake
// Defining LZA_CORRECT_EN adds a subtract-and-check stage, making out_lz exact and exposing out_corr.
module lza_pipe
  import lza_pkg::*;
#(
  parameter int W      = 25,
  parameter int GROUP  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4,
  parameter int CW     = lza_cw(W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_lz,
  output logic             out_zero,
`ifdef LZA_CORRECT_EN
  output logic             out_corr,
`endif
  output logic [TAG_W-1:0] out_tag
);

  localparam int NG = (W + GROUP - 1) / GROUP;
  localparam int PW = NG * GROUP;
  localparam int LW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam int SW = (NG > 1) ? $clog2(NG) : 1;
`ifdef LZA_CORRECT_EN
  localparam int NS = STAGES + 1;
`else
  localparam int NS = STAGES;
`endif

  typedef struct packed {
    logic [NG-1:0]    any;
    logic [NG*LW-1:0] loc;
    logic [TAG_W-1:0] tag;
`ifdef LZA_CORRECT_EN
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`endif
  } ind_t;

  typedef struct packed {
    logic [SW-1:0]    sel;
    logic [LW-1:0]    loc;
    logic             zero;
    logic [TAG_W-1:0] tag;
`ifdef LZA_CORRECT_EN
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`endif
  } grp_t;

  typedef struct packed {
    logic [CW-1:0]    lz;
    logic             zero;
    logic [TAG_W-1:0] tag;
`ifdef LZA_CORRECT_EN
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`endif
  } cnt_t;

  // Handshake: a stage loads when empty or when whatever sits behind it is leaving.
  logic [NS-1:0] v_q, v_d, ld, vin;

  always_comb begin
    vin = '0;
    ld  = '0;
    v_d = '0;
    vin[0] = in_valid;
    for (int k = 1; k < NS; k++) vin[k] = v_q[k-1];
    ld[NS-1] = ~v_q[NS-1] | out_ready;
    for (int k = NS - 2; k >= 0; k--) ld[k] = ~v_q[k] | ld[k+1];
    for (int k = 0; k < NS; k++) v_d[k] = ld[k] ? vin[k] : v_q[k];
  end

  always_ff @(posedge clk) begin
    if (rst) v_q <= '0;
    else     v_q <= v_d;
  end

  assign in_ready  = ld[0];
  assign out_valid = v_q[NS-1];

  // Step 1: indicator vector, LSB-padded to whole groups, then per-group encode.
  logic [W-1:0]     t_up, g_v, z_v, g_m1, z_m1, f_v;
  logic [PW-1:0]    f_pad;
  logic [NG-1:0]    s1_any;
  logic [NG*LW-1:0] s1_loc;
  ind_t             ind_d, ind_s;

  always_comb begin
    t_up  = {1'b1, ~(in_a[W-1:1] ^ in_b[W-1:1])};
    g_v   = in_a & ~in_b;
    z_v   = ~in_a & in_b;
    g_m1  = g_v << 1;
    z_m1  = z_v << 1;
    f_v   = ( t_up & ((g_v & ~z_m1) | (z_v & ~g_m1)))
          | (~t_up & ((z_v & ~z_m1) | (g_v & ~g_m1)));
    f_pad = '0;
    f_pad[PW-1 -: W] = f_v;
  end

  for (genvar p = 0; p < NG; p++) begin : g_grp
    lza_group_enc #(.N(GROUP), .IW(LW)) u_enc (
      .bits (f_pad[p*GROUP +: GROUP]),
      .any  (s1_any[p]),
      .idx  (s1_loc[p*LW +: LW])
    );
  end

  always_comb begin
    ind_d.any = s1_any;
    ind_d.loc = s1_loc;
    ind_d.tag = in_tag;
`ifdef LZA_CORRECT_EN
    ind_d.a   = in_a;
    ind_d.b   = in_b;
`endif
  end

  // Step 2: first non-empty group from the MSB end; group NG-1 is the top one.
  logic          grp_any;
  logic [SW-1:0] grp_sel;
  grp_t          grp_d, grp_s;

  lza_group_enc #(.N(NG), .IW(SW)) u_grp_enc (
    .bits (ind_s.any),
    .any  (grp_any),
    .idx  (grp_sel)
  );

  always_comb begin
    grp_d.sel  = grp_sel;
    grp_d.loc  = ind_s.loc[(NG - 1 - int'(grp_sel)) * LW +: LW];
    grp_d.zero = ~grp_any;
    grp_d.tag  = ind_s.tag;
`ifdef LZA_CORRECT_EN
    grp_d.a    = ind_s.a;
    grp_d.b    = ind_s.b;
`endif
  end

  // Step 3: combine group and local index, saturating at W.
  int   lz_sum;
  cnt_t cnt_d, cnt_q;

  always_comb begin
    lz_sum     = int'(grp_s.sel) * GROUP + int'(grp_s.loc);
    cnt_d.lz   = (grp_s.zero || lz_sum > W) ? CW'(W) : CW'(lz_sum);
    cnt_d.zero = grp_s.zero;
    cnt_d.tag  = grp_s.tag;
`ifdef LZA_CORRECT_EN
    cnt_d.a    = grp_s.a;
    cnt_d.b    = grp_s.b;
`endif
  end

  // Fewer stages merge steps from the output end: step 2+3 first, then all three.
  if (STAGES >= 2) begin : g_ind_reg
    ind_t ind_q;
    always_ff @(posedge clk) begin
      if (rst)                ind_q <= '0;
      else if (ld[0] && vin[0]) ind_q <= ind_d;
    end
    assign ind_s = ind_q;
  end else begin : g_ind_pass
    assign ind_s = ind_d;
  end

  if (STAGES >= 3) begin : g_grp_reg
    grp_t grp_q;
    always_ff @(posedge clk) begin
      if (rst)                grp_q <= '0;
      else if (ld[1] && vin[1]) grp_q <= grp_d;
    end
    assign grp_s = grp_q;
  end else begin : g_grp_pass
    assign grp_s = grp_d;
  end

  always_ff @(posedge clk) begin
    if (rst)                                  cnt_q <= '0;
    else if (ld[STAGES-1] && vin[STAGES-1])   cnt_q <= cnt_d;
  end

`ifdef LZA_CORRECT_EN
  typedef struct packed {
    logic [CW-1:0]    lz;
    logic             zero;
    logic             corr;
    logic [TAG_W-1:0] tag;
  } fix_t;

  fix_t         fix_d, fix_q;
  logic [W-1:0] diff;
  logic         sh_msb;

  // MSB of (A-B) << lz is simply bit W-1-lz of the difference.
  always_comb begin
    diff   = cnt_q.a - cnt_q.b;
    sh_msb = 1'b0;
    if (int'(cnt_q.lz) < W) sh_msb = diff[W - 1 - int'(cnt_q.lz)];
    fix_d.corr = ~cnt_q.zero & ~sh_msb;
    fix_d.lz   = cnt_q.lz + CW'(fix_d.corr);
    fix_d.zero = cnt_q.zero;
    fix_d.tag  = cnt_q.tag;
  end

  always_ff @(posedge clk) begin
    if (rst)                        fix_q <= '0;
    else if (ld[NS-1] && vin[NS-1]) fix_q <= fix_d;
  end

  assign out_lz   = fix_q.lz;
  assign out_zero = fix_q.zero;
  assign out_corr = fix_q.corr;
  assign out_tag  = fix_q.tag;
`else
  assign out_lz   = cnt_q.lz;
  assign out_zero = cnt_q.zero;
  assign out_tag  = cnt_q.tag;
`endif

endmodule

// File: tb/tb_lza_pipe.sv
// tb/tb_lza_pipe.sv - directed vectors, streaming, stall and reset checks for lza_pipe
// Configuration W=8, GROUP=4, STAGES=2; follows LZA_CORRECT_EN when the design is built with it.
module tb_lza_pipe;

  localparam int W      = 8;
  localparam int GROUP  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int CW     = 4;
`ifdef LZA_CORRECT_EN
  localparam int NS = STAGES + 1;
`else
  localparam int NS = STAGES;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_lz;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;
`ifdef LZA_CORRECT_EN
  logic             out_corr;
`endif

  always #5 clk = ~clk;

  lza_pipe #(.W(W), .GROUP(GROUP), .STAGES(STAGES), .TAG_W(TAG_W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
`ifdef LZA_CORRECT_EN
    .out_corr  (out_corr),
`endif
    .out_tag   (out_tag)
  );

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [TAG_W-1:0] tag;
  } item_t;

  item_t        exp_q[$];
  logic [W-1:0] va[0:31];
  logic [W-1:0] vb[0:31];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clz(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) if (v[i]) return W - 1 - i;
    return W;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] tag, input int lz_ant, input int lz_fix,
                         input int corr, input int zero);
    int lat;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    out_ready = 1'b1;
    #1;
    check_eq({name, "_in_ready"}, int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check_eq({name, "_latency"}, lat, NS);
`ifdef LZA_CORRECT_EN
    check_eq({name, "_lz"}, int'(out_lz), lz_fix);
    check_eq({name, "_corr"}, int'(out_corr), corr);
`else
    check_eq({name, "_lz"}, int'(out_lz), lz_ant);
`endif
    check_eq({name, "_zero"}, int'(out_zero), zero);
    check_eq({name, "_tag"}, int'(out_tag), int'(tag));
    tick();
  endtask

  task automatic stream(input string name, input int base, input int n,
                        input int stall_at, input int stall_len);
    int sent, rcv, cyc, rf;
    bit held, saw_block;
    logic [CW-1:0] h_lz;
    logic [TAG_W-1:0] h_tag;
    item_t ex;
    sent = 0; rcv = 0; cyc = 0; held = 0; saw_block = 0;
    h_lz = '0; h_tag = '0;
    while (rcv < n && cyc < 300) begin
      out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      in_valid  = (sent < n);
      in_a      = va[base + (sent % 16)];
      in_b      = vb[base + (sent % 16)];
      in_tag    = TAG_W'(sent);
      #1;
      if (held) begin
        check_eq({name, "_hold_valid"}, int'(out_valid), 1);
        check_eq({name, "_hold_lz"}, int'(out_lz), int'(h_lz));
        check_eq({name, "_hold_tag"}, int'(out_tag), int'(h_tag));
      end
      if (in_valid && !in_ready) saw_block = 1;
      if (in_valid && in_ready) begin
        exp_q.push_back('{a: in_a, b: in_b, tag: in_tag});
        sent++;
      end
      held  = out_valid && !out_ready;
      h_lz  = out_lz;
      h_tag = out_tag;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq({name, "_spurious_output"}, 1, 0);
        end else begin
          ex = exp_q.pop_front();
          rf = clz(ex.a - ex.b);
          check_eq({name, "_tag"}, int'(out_tag), int'(ex.tag));
          check_eq({name, "_zero"}, int'(out_zero), int'(ex.a == ex.b));
`ifdef LZA_CORRECT_EN
          check_eq({name, "_lz_exact"}, int'(out_lz), rf);
`else
          check_eq($sformatf("%s_lz_window(lz=%0d,true=%0d)", name, out_lz, rf),
                   int'(int'(out_lz) == rf || int'(out_lz) + 1 == rf), 1);
`endif
        end
        rcv++;
      end
      tick();
      cyc++;
    end
    check_eq({name, "_received"}, rcv, n);
    check_eq({name, "_cycles"}, cyc, n + NS + stall_len);
    if (stall_len > 0) check_eq({name, "_in_ready_dropped"}, int'(saw_block), 1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      logic [W-1:0] x, y, s;
      x = W'($urandom_range(0, 255));
      y = (i % 7 == 3) ? x : W'($urandom_range(0, 255));
      if (x < y) begin s = x; x = y; y = s; end
      va[i] = x;
      vb[i] = y;
    end

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b0;
    @(negedge clk);
    tick();
    tick();
    check_eq("reset_out_valid", int'(out_valid), 0);
    check_eq("reset_out_lz", int'(out_lz), 0);
    check_eq("reset_out_zero", int'(out_zero), 0);
    check_eq("reset_out_tag", int'(out_tag), 0);
    check_eq("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    tick();

    run_vec("v10_00", 8'h10, 8'h00, 4'h1, 3, 3, 0, 0);
    run_vec("v80_7f", 8'h80, 8'h7F, 4'h2, 7, 7, 0, 0);
    run_vec("v5a_5a", 8'h5A, 8'h5A, 4'h3, 8, 8, 0, 1);
    run_vec("v20_01", 8'h20, 8'h01, 4'h4, 2, 3, 1, 0);
    run_vec("v03_01", 8'h03, 8'h01, 4'h5, 6, 6, 0, 0);

    stream("stream", 0, 16, 1000, 0);
    stream("stall", 16, 12, 4, 5);

    // Two results in flight, then reset.
    out_ready = 1'b0;
    in_valid  = 1'b1; in_a = 8'h10; in_b = 8'h00; in_tag = 4'hA;
    tick();
    in_tag = 4'hB;
    tick();
    in_valid = 1'b0;
    check_eq("pre_reset_out_valid", int'(out_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("post_reset_out_valid", int'(out_valid), 0);
    check_eq("post_reset_in_ready", int'(in_ready), 1);
    check_eq("post_reset_out_tag", int'(out_tag), 0);
    tick();
    tick();
    check_eq("post_reset_no_leftover", int'(out_valid), 0);
    run_vec("after_reset", 8'h03, 8'h01, 4'h7, 6, 6, 0, 0);
    check_eq("after_reset_drained", int'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
